// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, FSM states,
// datapath select codes and trap causes.
package multicycle_ctrl_pkg;

  localparam int unsigned OPCODE_W = 7;

  localparam logic [OPCODE_W-1:0] OP_R    = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_LW   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_SW   = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL  = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_LUI  = 7'b0110111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } ctrl_state_t;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_RFN  = 2'b10;
  localparam logic [1:0] ALU_IFN  = 2'b11;

  localparam logic [1:0] PC_SRC_SEQ  = 2'b00;
  localparam logic [1:0] PC_SRC_TGT  = 2'b01;
  localparam logic [1:0] PC_SRC_JALR = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MDR  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_MEM_TO  = 2'b10;

  // Opcodes the datapath can execute; anything else traps in DECODE.
  function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
    logic legal;
    case (op)
      OP_R, OP_LW, OP_ADDI, OP_SW, OP_BEQ, OP_JAL, OP_JALR, OP_LUI: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Counts consecutive stalled memory-request cycles and flags the cycle in
// which the request has waited long enough to be abandoned.
module multicycle_ctrl_mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic ready_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall;

  assign stall     = req_i && !ready_i;
  assign expired_o = stall && (cnt_q == LAST);

  // Any cycle that is not a stall (ready, idle, or expiry) restarts the count.
  always_comb begin
    cnt_d = '0;
    if (stall && !expired_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives
// datapath strobes and selects, owns the memory handshake and traps on errors.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       run_i,
  input  logic [6:0] opcode_i,
  input  logic       br_taken_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic [1:0] pc_src_o,
  output logic       reg_we_o,
  output logic [1:0] wb_sel_o,
  output logic       alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic       busy_o,
  output logic       trap_o,
  output logic [1:0] trap_cause_o
);

  ctrl_state_t state_q, state_d;
  ctrl_state_t done_state;
  logic [1:0]  cause_q, cause_d;
  logic        mem_expired;

  logic is_r, is_lw, is_addi, is_sw, is_beq, is_jal, is_jalr, is_lui;

  assign is_r    = (opcode_i == OP_R);
  assign is_lw   = (opcode_i == OP_LW);
  assign is_addi = (opcode_i == OP_ADDI);
  assign is_sw   = (opcode_i == OP_SW);
  assign is_beq  = (opcode_i == OP_BEQ);
  assign is_jal  = (opcode_i == OP_JAL);
  assign is_jalr = (opcode_i == OP_JALR);
  assign is_lui  = (opcode_i == OP_LUI);

  // Back-to-back instructions skip the IDLE bubble when run is already high.
  assign done_state   = run_i ? ST_FETCH : ST_IDLE;
  assign trap_cause_o = cause_q;

  multicycle_ctrl_mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (mem_req_o),
    .ready_i   (mem_ready_i),
    .expired_o (mem_expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cause_q <= TRAP_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      ST_IDLE: begin
        if (run_i) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_ready_i) begin
          state_d = ST_DECODE;
        end else if (mem_expired) begin
          state_d = ST_TRAP;
          cause_d = TRAP_MEM_TO;
        end
      end
      ST_DECODE: begin
        if (is_legal(opcode_i)) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_TRAP;
          cause_d = TRAP_ILLEGAL;
        end
      end
      ST_EXEC: begin
        if (is_beq)              state_d = done_state;
        else if (is_lw || is_sw) state_d = ST_MEM;
        else                     state_d = ST_WB;
      end
      ST_MEM: begin
        if (mem_ready_i) begin
          state_d = is_lw ? ST_WB : done_state;
        end else if (mem_expired) begin
          state_d = ST_TRAP;
          cause_d = TRAP_MEM_TO;
        end
      end
      ST_WB:   state_d = done_state;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    iord_o      = 1'b0;
    ir_we_o     = 1'b0;
    pc_we_o     = 1'b0;
    pc_src_o    = PC_SRC_SEQ;
    reg_we_o    = 1'b0;
    wb_sel_o    = WB_ALU;
    alu_src_b_o = 1'b0;
    alu_op_o    = ALU_ADD;
    busy_o      = 1'b0;
    trap_o      = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req_o = 1'b1;
        ir_we_o   = mem_ready_i;
        pc_we_o   = mem_ready_i;
        busy_o    = 1'b1;
      end
      ST_DECODE: busy_o = 1'b1;
      ST_EXEC: begin
        busy_o = 1'b1;
        if (is_r) begin
          alu_op_o = ALU_RFN;
        end else if (is_addi) begin
          alu_src_b_o = 1'b1;
          alu_op_o    = ALU_IFN;
        end else if (is_lw || is_sw || is_jalr || is_lui) begin
          alu_src_b_o = 1'b1;
        end else if (is_beq) begin
          alu_op_o = ALU_SUB;
          pc_we_o  = br_taken_i;
          pc_src_o = PC_SRC_TGT;
        end
      end
      ST_MEM: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
        mem_we_o  = is_sw;
        busy_o    = 1'b1;
      end
      ST_WB: begin
        busy_o   = 1'b1;
        reg_we_o = 1'b1;
        if (is_lw)                wb_sel_o = WB_MDR;
        else if (is_jal || is_jalr) wb_sel_o = WB_LINK;
        if (is_jal) begin
          pc_we_o  = 1'b1;
          pc_src_o = PC_SRC_TGT;
        end else if (is_jalr) begin
          pc_we_o  = 1'b1;
          pc_src_o = PC_SRC_JALR;
        end
      end
      ST_TRAP: trap_o = 1'b1;
      default: ;
    endcase
  end

endmodule
